sys_reg_file: RTL and testbench

// - Register bank directly downstream of sys_ctrl. Serves its Address/WrEn/RdEn/WrData requests and returns RdData/RdData_Valid.
// - Entries 0..3 are reserved system registers and are exported continuously:
//   - REG0: ALU operand A
//   - REG1: ALU operand B
//   - REG2: UART config
//   - REG3: clock-divider ratio
// - Single clock domain (CLK_IN). 1-cycle registered read latency.

---
 rtl/sys_reg_file_if.sv | 30 +++
 rtl/sys_reg_file.sv | 165 ++++++++++++++++
 tb/tb_sys_reg_file.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_reg_file_if.sv
// -----------------------------------------------------------------------------
// sys_reg_file_if
// Request/response bus between sys_ctrl (master) and sys_reg_file (slave).
//   Address      : entry select, sampled together with WrEn/RdEn
//   WrEn / RdEn  : write / read strobes, level-sampled every cycle
//   WrData       : write data
//   RdData       : registered read data, held between reads
//   RdData_Valid : one-cycle pulse qualifying RdData
// -----------------------------------------------------------------------------
interface sys_reg_file_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] Address;
  logic              WrEn;
  logic              RdEn;
  logic [WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]  RdData;
  logic              RdData_Valid;

  modport master (
    output Address, WrEn, RdEn, WrData,
    input  RdData, RdData_Valid
  );

  modport slave (
    input  Address, WrEn, RdEn, WrData,
    output RdData, RdData_Valid
  );
endinterface

// File: rtl/sys_reg_file.sv
// -----------------------------------------------------------------------------
// sys_reg_file
// Register bank serving sys_ctrl read/write requests. Entries 0..3 are system
// registers exported continuously (ALU operand A/B, UART config, divider).
// Reads have one cycle of registered latency.
//
// Ports
//   CLK_IN      : system clock
//   RST_IN      : asynchronous, active-low reset
//   bus         : sys_reg_file_if slave (Address/WrEn/RdEn/WrData in,
//                 RdData/RdData_Valid out)
//   REG0..REG3  : live contents of entries 0..3
//   cfg_update  : one-cycle pulse after REG2 or REG3 changes value
//   parity_err  : read-parity error, aligned with RdData_Valid
//
// Optional feature: define REG_FILE_PARITY_EN to store an even-parity bit per
// entry and check it on every read. Without it parity_err is tied low.
// -----------------------------------------------------------------------------
module sys_reg_file #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      ADDR_W   = 4,
  parameter logic [WIDTH-1:0] REG2_RST = WIDTH'(8'h81),
  parameter logic [WIDTH-1:0] REG3_RST = WIDTH'(8'h20)
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  sys_reg_file_if.slave    bus,
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3,
  output logic             cfg_update,
  output logic             parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_REG2 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_REG3 = ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t state;
  state_t next_state;

  logic             wr_fire;
  logic             rd_fire;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] cur_word;
  logic             cfg_addr;
  logic [WIDTH-1:0] rd_data_q;
  logic             cfg_update_q;

  function automatic logic [WIDTH-1:0] reset_word(input int unsigned idx);
    if (idx == 2)      return REG2_RST;
    else if (idx == 3) return REG3_RST;
    else               return '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle-type FSM. The registered state describes the access sampled at the
  // previous edge, so ST_READ is exactly the cycle in which RdData is valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = ST_IDLE;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    case ({bus.WrEn, bus.RdEn})
      2'b10: begin
        next_state = ST_WRITE;
        wr_fire    = 1'b1;
      end
      2'b01: begin
        next_state = ST_READ;
        rd_fire    = 1'b1;
      end
      // Simultaneous WrEn/RdEn is an illegal request and is dropped.
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.RdData_Valid = (state == ST_READ);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign cur_word = mem[bus.Address];
  assign cfg_addr = (bus.Address == ADDR_REG2) || (bus.Address == ADDR_REG3);

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_word(i);
      end
    end else if (wr_fire) begin
      mem[bus.Address] <= bus.WrData;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: captured only on a legal read, otherwise held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN)      rd_data_q <= '0;
    else if (rd_fire) rd_data_q <= cur_word;
  end

  assign bus.RdData = rd_data_q;

  // ---------------------------------------------------------------------------
  // Config-change pulse: compares against the pre-write content so that a
  // same-value write to REG2/REG3 produces no pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) cfg_update_q <= 1'b0;
    else         cfg_update_q <= wr_fire && cfg_addr && (cur_word != bus.WrData);
  end

  assign cfg_update = cfg_update_q;

  assign REG0 = mem[0];
  assign REG1 = mem[1];
  assign REG2 = mem[2];
  assign REG3 = mem[3];

  // ---------------------------------------------------------------------------
  // Optional per-entry parity
  // ---------------------------------------------------------------------------
`ifdef REG_FILE_PARITY_EN
  logic mem_par [DEPTH];
  logic parity_err_q;

  // Even parity: stored bit equals the XOR of the data bits, so data plus
  // parity always carries an even number of ones.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_par[i] <= ^reset_word(i);
      end
    end else if (wr_fire) begin
      mem_par[bus.Address] <= ^bus.WrData;
    end
  end

  // Registered alongside rd_data_q so the flag lines up with RdData_Valid.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) parity_err_q <= 1'b0;
    else         parity_err_q <= rd_fire && ((^cur_word) != mem_par[bus.Address]);
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sys_reg_file.sv
module tb_sys_reg_file;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 4;

  logic             CLK_IN = 1'b0;
  logic             RST_IN;
  logic [WIDTH-1:0] REG0, REG1, REG2, REG3;
  logic             cfg_update;
  logic             parity_err;

  always #5 CLK_IN = ~CLK_IN;

  sys_reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  sys_reg_file #(
    .WIDTH(WIDTH),
    .ADDR_W(ADDR_W),
    .REG2_RST(8'h81),
    .REG3_RST(8'h20)
  ) dut (
    .CLK_IN(CLK_IN),
    .RST_IN(RST_IN),
    .bus(bus),
    .REG0(REG0),
    .REG1(REG1),
    .REG2(REG2),
    .REG3(REG3),
    .cfg_update(cfg_update),
    .parity_err(parity_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: an array of entries plus the expected response of the
  // most recent cycle.
  logic [7:0] m_mem [16];
  logic [7:0] exp_rd;
  logic       exp_valid;
  logic       exp_cfg;
  logic       exp_perr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_mem[2]  = 8'h81;
    m_mem[3]  = 8'h20;
    exp_rd    = 8'h00;
    exp_valid = 1'b0;
    exp_cfg   = 1'b0;
    exp_perr  = 1'b0;
  endtask

  // Drives one request for one clock edge, advances the model, and returns at
  // the following falling edge with the bus idle.
  task automatic drive_cycle(input logic we, input logic re,
                             input logic [3:0] a, input logic [7:0] d);
    bus.WrEn    = we;
    bus.RdEn    = re;
    bus.Address = a;
    bus.WrData  = d;
    @(posedge CLK_IN);
    exp_valid = re && !we;
    if (exp_valid) exp_rd = m_mem[a];
    exp_perr = 1'b0;
    exp_cfg  = we && !re && (a == 4'd2 || a == 4'd3) && (m_mem[a] != d);
    if (we && !re) m_mem[a] = d;
    @(negedge CLK_IN);
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
  endtask

  task automatic test_reset();
    bus.WrEn = 1'b0; bus.RdEn = 1'b0; bus.Address = '0; bus.WrData = '0;
    RST_IN = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK_IN);
    RST_IN = 1'b1;
    @(negedge CLK_IN);
    total_cnt++;
    if ({REG3, REG2, REG1, REG0} !== 32'h2081_0000)
      $display("FAIL reset_regs: got %h expected %h", {REG3, REG2, REG1, REG0}, 32'h2081_0000);
    else pass_cnt++;
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.RdData_Valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.RdData !== 8'h00) $display("FAIL reset_rddata: got %h expected 00", bus.RdData);
    else pass_cnt++;
    total_cnt++;
    if (cfg_update !== 1'b0 || parity_err !== 1'b0)
      $display("FAIL reset_flags: got cfg=%b perr=%b expected 0/0", cfg_update, parity_err);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 1'b0, 4'd5, 8'hA5);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0) $display("FAIL wr_valid: got %b expected 0", bus.RdData_Valid);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b1, 4'd5, 8'h00);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b1 || bus.RdData !== 8'hA5)
      $display("FAIL rd_addr5: got valid=%b data=%h expected 1/a5", bus.RdData_Valid, bus.RdData);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b0, 4'd0, 8'h00);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0 || bus.RdData !== 8'hA5)
      $display("FAIL rd_hold: got valid=%b data=%h expected 0/a5", bus.RdData_Valid, bus.RdData);
    else pass_cnt++;
  endtask

  task automatic test_cfg_update();
    drive_cycle(1'b1, 1'b0, 4'd3, 8'h08);
    total_cnt++;
    if (cfg_update !== 1'b1 || REG3 !== 8'h08)
      $display("FAIL cfg_reg3_change: got cfg=%b reg3=%h expected 1/08", cfg_update, REG3);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b0, 4'd0, 8'h00);
    total_cnt++;
    if (cfg_update !== 1'b0) $display("FAIL cfg_one_cycle: got %b expected 0", cfg_update);
    else pass_cnt++;
    drive_cycle(1'b1, 1'b0, 4'd3, 8'h08);
    total_cnt++;
    if (cfg_update !== 1'b0) $display("FAIL cfg_same_value: got %b expected 0", cfg_update);
    else pass_cnt++;
    drive_cycle(1'b1, 1'b0, 4'd0, 8'h33);
    total_cnt++;
    if (cfg_update !== 1'b0 || REG0 !== 8'h33)
      $display("FAIL cfg_reg0: got cfg=%b reg0=%h expected 0/33", cfg_update, REG0);
    else pass_cnt++;
    drive_cycle(1'b1, 1'b0, 4'd2, 8'h55);
    total_cnt++;
    if (cfg_update !== 1'b1 || REG2 !== 8'h55)
      $display("FAIL cfg_reg2_change: got cfg=%b reg2=%h expected 1/55", cfg_update, REG2);
    else pass_cnt++;
    drive_cycle(1'b1, 1'b0, 4'd12, 8'h99);
    total_cnt++;
    if (cfg_update !== 1'b0) $display("FAIL cfg_high_addr: got %b expected 0", cfg_update);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [7:0] held;
    held = exp_rd;
    drive_cycle(1'b1, 1'b1, 4'd7, 8'hFF);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0 || bus.RdData !== held)
      $display("FAIL illegal_noread: got valid=%b data=%h expected 0/%h", bus.RdData_Valid, bus.RdData, held);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b1, 4'd7, 8'h00);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b1 || bus.RdData !== 8'h00)
      $display("FAIL illegal_nowrite: got valid=%b data=%h expected 1/00", bus.RdData_Valid, bus.RdData);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 4'(i), vals[i]);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 4'(i), 8'h00);
      total_cnt++;
      if (bus.RdData_Valid !== 1'b1 || bus.RdData !== vals[i])
        $display("FAIL b2b_read%0d: got valid=%b data=%h expected 1/%h", i, bus.RdData_Valid, bus.RdData, vals[i]);
      else pass_cnt++;
    end
    drive_cycle(1'b0, 1'b0, 4'd0, 8'h00);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0) $display("FAIL b2b_end: got %b expected 0", bus.RdData_Valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    drive_cycle(1'b1, 1'b0, 4'd4, 8'h5A);
    // Reset lands just after the read edge: the valid pulse must be cut off.
    bus.RdEn = 1'b1; bus.Address = 4'd4;
    @(posedge CLK_IN);
    #2 RST_IN = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0 || bus.RdData !== 8'h00)
      $display("FAIL rst_mid_drop: got valid=%b data=%h expected 0/00", bus.RdData_Valid, bus.RdData);
    else pass_cnt++;
    total_cnt++;
    if ({REG3, REG2, REG1, REG0} !== 32'h2081_0000)
      $display("FAIL rst_mid_regs: got %h expected %h", {REG3, REG2, REG1, REG0}, 32'h2081_0000);
    else pass_cnt++;
    // Read request held across an edge while in reset: no pulse.
    @(posedge CLK_IN);
    #1;
    total_cnt++;
    if (bus.RdData_Valid !== 1'b0) $display("FAIL rst_hold_valid: got %b expected 0", bus.RdData_Valid);
    else pass_cnt++;
    @(negedge CLK_IN);
    bus.RdEn = 1'b0;
    RST_IN = 1'b1;
    drive_cycle(1'b0, 1'b1, 4'd4, 8'h00);
    total_cnt++;
    if (bus.RdData_Valid !== 1'b1 || bus.RdData !== 8'h00)
      $display("FAIL rst_mem_cleared: got valid=%b data=%h expected 1/00", bus.RdData_Valid, bus.RdData);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic       we, re;
    logic [3:0] a;
    logic [7:0] d;
    int unsigned kind;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      we = (kind < 4) || (kind == 9);
      re = (kind >= 4 && kind < 8) || (kind == 9);
      a  = (kind < 4 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(2, 3)) : 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 2) == 0) ? m_mem[a] : 8'($urandom);
      drive_cycle(we, re, a, d);
      total_cnt++;
      if (bus.RdData_Valid !== exp_valid || bus.RdData !== exp_rd)
        $display("FAIL rand_read[%0d]: got valid=%b data=%h expected %b/%h", n, bus.RdData_Valid, bus.RdData, exp_valid, exp_rd);
      else pass_cnt++;
      total_cnt++;
      if (cfg_update !== exp_cfg || parity_err !== exp_perr)
        $display("FAIL rand_flags[%0d]: got cfg=%b perr=%b expected %b/%b", n, cfg_update, parity_err, exp_cfg, exp_perr);
      else pass_cnt++;
      total_cnt++;
      if ({REG3, REG2, REG1, REG0} !== {m_mem[3], m_mem[2], m_mem[1], m_mem[0]})
        $display("FAIL rand_regs[%0d]: got %h expected %h", n, {REG3, REG2, REG1, REG0}, {m_mem[3], m_mem[2], m_mem[1], m_mem[0]});
      else pass_cnt++;
    end
  endtask

  task automatic test_parity();
    drive_cycle(1'b1, 1'b0, 4'd9, 8'h3C);
`ifdef REG_FILE_PARITY_EN
    dut.mem_par[9] = ~dut.mem_par[9];
    drive_cycle(1'b0, 1'b1, 4'd9, 8'h00);
    total_cnt++;
    if (parity_err !== 1'b1 || bus.RdData_Valid !== 1'b1)
      $display("FAIL parity_flip: got perr=%b valid=%b expected 1/1", parity_err, bus.RdData_Valid);
    else pass_cnt++;
`else
    drive_cycle(1'b0, 1'b1, 4'd9, 8'h00);
    total_cnt++;
    if (parity_err !== 1'b0 || bus.RdData !== 8'h3C)
      $display("FAIL parity_tied: got perr=%b data=%h expected 0/3c", parity_err, bus.RdData);
    else pass_cnt++;
`endif
    drive_cycle(1'b0, 1'b1, 4'd5, 8'h00);
    total_cnt++;
    if (parity_err !== 1'b0) $display("FAIL parity_clean: got %b expected 0", parity_err);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b0, 4'd0, 8'h00);
    total_cnt++;
    if (parity_err !== 1'b0) $display("FAIL parity_idle: got %b expected 0", parity_err);
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_cfg_update();
    test_illegal();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
